// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulus counter.
package mod_counter_pkg;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count computation for one enabled count cycle.
// Reports whether the result wrapped or clipped, and whether the step was illegal.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  mode_e            mode,
    input  logic             up_down,
    output logic [WIDTH-1:0] next,
    output logic             wrap,
    output logic             illegal
);
    logic [WIDTH:0] sum;

    always_comb begin
        next    = count;
        wrap    = 1'b0;
        illegal = 1'b0;
        sum     = {1'b0, count} + {1'b0, step};
        if (step > limit) begin
            illegal = 1'b1;
        end else if (up_down) begin
            if (sum <= {1'b0, limit}) begin
                next = sum[WIDTH-1:0];
            end else begin
                wrap = 1'b1;
                // ~limit == -(limit+1) mod 2^WIDTH; wrapped results lie in 0..limit,
                // so WIDTH-bit modular arithmetic yields them exactly.
                next = (mode == MODE_SAT) ? limit : (count + step + ~limit);
            end
        end else begin
            if (step <= count) begin
                next = count - step;
            end else begin
                wrap = 1'b1;
                next = (mode == MODE_SAT) ? '0 : (count - (step + ~limit));
            end
        end
    end
endmodule

// File: rtl/mod_counter.sv
// Up/down modulus counter with wrap/saturate mode, terminal pulse and step-error pulse.
// Optional sticky terminal flag enabled by defining MOD_COUNTER_STICKY_EN.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MOD_COUNTER_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_tc,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] data_load,
    input  logic             ce,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero,
    output logic             tc,
    output logic             step_err
);
    logic [WIDTH-1:0] count_reg, count_next, arith_next;
    logic             tc_reg, tc_next, step_err_reg, step_err_next;
    logic             arith_wrap, arith_illegal;

    mod_counter_next #(.WIDTH(WIDTH)) u_next (
        .count   (count_reg),
        .step    (step),
        .limit   (limit),
        .mode    (mode_e'(mode)),
        .up_down (up_down),
        .next    (arith_next),
        .wrap    (arith_wrap),
        .illegal (arith_illegal)
    );

    always_comb begin
        count_next    = count_reg;
        tc_next       = 1'b0;
        step_err_next = 1'b0;
        if (load) begin
            count_next = (data_load > limit) ? limit : data_load;
        end else if (count_reg > limit) begin
            // limit was lowered below the current count
            count_next = limit;
            tc_next    = 1'b1;
        end else if (ce) begin
            count_next    = arith_next;
            tc_next       = arith_wrap;
            step_err_next = arith_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            tc_reg       <= 1'b0;
            step_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            tc_reg       <= tc_next;
            step_err_reg <= step_err_next;
        end
    end

`ifdef MOD_COUNTER_STICKY_EN
    logic sticky_reg;

    always_ff @(posedge clk) begin
        if (rst)
            sticky_reg <= 1'b0;
        else if (tc_next)
            sticky_reg <= 1'b1;
        else if (sticky_clr)
            sticky_reg <= 1'b0;
    end

    assign sticky_tc = sticky_reg;
`endif

    assign count_out = count_reg;
    assign tc        = tc_reg;
    assign step_err  = step_err_reg;
    assign max_count = (count_reg == limit);
    assign zero      = (count_reg == '0);
endmodule

// File: tb/tb_mod_counter.sv
// Randomised scoreboard bench for mod_counter (WIDTH = 4) with directed corner cases.
module tb_mod_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] data_load = '0;
    logic       ce = 1'b0;
    logic       up_down = 1'b0;
    logic [3:0] step = '0;
    logic [3:0] limit = '0;
    logic       mode = 1'b0;
    logic       sticky_clr = 1'b0;
    logic [3:0] count_out;
    logic       max_count, zero, tc, step_err;
    logic       sticky_tc;

    mod_counter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MOD_COUNTER_STICKY_EN
        .sticky_clr(sticky_clr),
        .sticky_tc (sticky_tc),
`endif
        .load      (load),
        .data_load (data_load),
        .ce        (ce),
        .up_down   (up_down),
        .step      (step),
        .limit     (limit),
        .mode      (mode),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .tc        (tc),
        .step_err  (step_err)
    );

`ifndef MOD_COUNTER_STICKY_EN
    assign sticky_tc = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       err;
        logic       mx;
        logic       zr;
        logic       st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   txn = 0;

    // reference model state
    int   m_cnt = 0;
    bit   m_sticky = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input int dl, input bit c, input bit ud,
                         input int st, input int lm, input bit md, input bit sc);
        exp_t e;
        bit   t, er;
        @(negedge clk);
        rst = r; load = ld; data_load = 4'(dl); ce = c; up_down = ud;
        step = 4'(st); limit = 4'(lm); mode = md; sticky_clr = sc;
        t = 0; er = 0;
        if (r) begin
            m_cnt = 0; m_sticky = 0;
        end else begin
            if (ld) begin
                m_cnt = (dl < lm) ? dl : lm;
            end else if (m_cnt > lm) begin
                m_cnt = lm; t = 1;
            end else if (c) begin
                if (st > lm) er = 1;
                else if (ud) begin
                    if (m_cnt + st <= lm) m_cnt = m_cnt + st;
                    else begin t = 1; m_cnt = md ? lm : (m_cnt + st) % (lm + 1); end
                end else begin
                    if (m_cnt >= st) m_cnt = m_cnt - st;
                    else begin t = 1; m_cnt = md ? 0 : (m_cnt - st + lm + 1) % (lm + 1); end
                end
            end
            if (t) m_sticky = 1;
            else if (sc) m_sticky = 0;
        end
        e.cnt = 4'(m_cnt); e.tc = t; e.err = er;
        e.mx = (m_cnt == lm); e.zr = (m_cnt == 0);
`ifdef MOD_COUNTER_STICKY_EN
        e.st = m_sticky;
`else
        e.st = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    // monitor: outputs are valid every cycle, checked 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                check("count_out", count_out, e.cnt);
                check("tc", tc, e.tc);
                check("step_err", step_err, e.err);
                check("max_count", max_count, e.mx);
                check("zero", zero, e.zr);
                check("sticky_tc", sticky_tc, e.st);
                $display("txn %0d: count=%0d tc=%0b err=%0b max=%0b zero=%0b sticky=%0b",
                         txn, count_out, tc, step_err, max_count, zero, sticky_tc);
            end
        end
    end

    initial begin
        int lm, wait_cycles;
        // reset from count 7, limit 0 afterwards
        drive(1, 0, 0, 0, 0, 0, 9, 0, 0);
        drive(0, 1, 7, 0, 0, 0, 9, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // wrap up: 8 + 3 with limit 9 -> 1, then 4
        drive(0, 1, 8, 0, 1, 3, 9, 0, 0);
        drive(0, 0, 0, 1, 1, 3, 9, 0, 0);
        drive(0, 0, 0, 1, 1, 3, 9, 0, 0);
        // wrap down, then saturate down twice
        drive(0, 1, 1, 0, 0, 3, 15, 0, 0);
        drive(0, 0, 0, 1, 0, 3, 15, 0, 0);
        drive(0, 1, 2, 0, 0, 5, 15, 1, 0);
        drive(0, 0, 0, 1, 0, 5, 15, 1, 0);
        drive(0, 0, 0, 1, 0, 5, 15, 1, 0);
        // saturate up at the bound
        drive(0, 1, 15, 0, 1, 2, 15, 1, 0);
        drive(0, 0, 0, 1, 1, 2, 15, 1, 0);
        // load clipped to limit with ce ignored, then range clamp
        drive(0, 1, 12, 1, 1, 1, 9, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 5, 0, 0);
        // illegal step, then zero step
        drive(0, 1, 4, 0, 1, 0, 9, 0, 0);
        drive(0, 0, 0, 1, 1, 11, 9, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 9, 0, 0);
        // sticky: wrap, idle, wrap with clear, clear alone
        drive(0, 1, 8, 0, 1, 3, 9, 0, 0);
        drive(0, 0, 0, 1, 1, 3, 9, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 9, 0, 0);
        drive(0, 1, 8, 0, 1, 3, 9, 0, 0);
        drive(0, 0, 0, 1, 1, 3, 9, 0, 1);
        drive(0, 0, 0, 0, 1, 3, 9, 0, 1);
        // randomised traffic
        lm = 9;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) lm = $urandom_range(15);
            drive($urandom_range(49) == 0, $urandom_range(9) == 0, $urandom_range(15),
                  $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(15),
                  lm, $urandom_range(1) == 1, $urandom_range(5) == 0);
        end
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised up/down counter; successor to the fixed-range WIDTH counter.
- Adds a programmable modulus limit, a variable step size and a wrap/saturate mode.
- Adds a registered terminal-event pulse and illegal-step detection.
- Sits in the counter library as a drop-in event/timer counter for datapath and test blocks.

Parameters:
- WIDTH, 4, bit width of count, data_load, step and limit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  active-high synchronous load of data_load.
- data_load  input  WIDTH  value to load.
- ce  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- step  input  WIDTH  increment/decrement magnitude per enabled cycle.
- limit  input  WIDTH  inclusive upper bound; legal range is 0..limit.
- mode  input  1  0 = MODE_WRAP, 1 = MODE_SAT.
- count_out  output  WIDTH  registered count.
- max_count  output  1  combinational: count_out == limit.
- zero  output  1  combinational: count_out == 0.
- tc  output  1  registered one-cycle pulse after a wrap or saturation clip.
- step_err  output  1  registered one-cycle pulse after an illegal-step attempt.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: count_out = 0, tc = 0, step_err = 0; hence zero = 1, and max_count = 1 only if limit == 0.
- Per-edge priority: rst > load > range clamp > ce count > hold.
- load: count_out <= min(data_load, limit); tc = 0; step_err = 0; ce is ignored that cycle.
- Range clamp: no rst/load and count_out > limit (limit lowered mid-run): count_out <= limit; tc = 1; ce ignored.
- Illegal step: ce = 1 and step > limit: count holds; step_err = 1 next cycle; tc = 0.
- step == 0 with ce = 1: count holds; no tc.
- Arithmetic in WIDTH+1 bits; the modulus M = limit + 1 is held on WIDTH+1 bits, so limit = all-ones gives M = 2^WIDTH.
- Up count, sum = count_out + step:
  - sum <= limit: count_out <= sum.
  - Otherwise, MODE_WRAP: sum - M, tc = 1.
  - Otherwise, MODE_SAT: limit, tc = 1.
- Down count:
  - step <= count_out: count_out <= count_out - step.
  - Otherwise, MODE_WRAP: count_out + M - step, tc = 1.
  - Otherwise, MODE_SAT: 0, tc = 1.
- MODE_SAT already at the bound and pushing further (e.g. at limit counting up with step > 0): count_out stays at the bound; tc = 1 each such cycle.
- Latency:
  - count_out updates 1 cycle after the inputs are sampled.
  - tc and step_err assert in the same cycle the new count_out is visible.
  - Both are 0 on every cycle with no qualifying event.
- mode, limit and step may change on any cycle; they are sampled only at the edge.
- rst asserted mid-sequence overrides everything in that cycle.

Optional Feature:
- Macro: MOD_COUNTER_STICKY_EN.
- Defined: adds input sticky_clr (1) and output sticky_tc (1).
  - sticky_tc sets on any cycle where tc sets.
  - sticky_tc clears on rst or sticky_clr.
  - If set and clear occur together, set wins.
  - Reset value 0.
- Undefined: neither port exists; no extra state.

Decomposition:
- Package mod_counter_pkg:
  - typedef enum logic {MODE_WRAP = 0, MODE_SAT = 1} mode_e;
  - localparam DEFAULT_WIDTH = 4.
- Sub-module mod_counter_next (combinational):
  - Inputs: count, step, limit, mode, up_down.
  - Outputs: next count, wrap/clip flag, illegal-step flag.
- The top holds only the registers and the priority mux.

Test Plan (WIDTH = 4):
- rst = 1 for 2 cycles at count 7 -> count_out = 0, zero = 1, tc = 0, step_err = 0; with limit = 0, max_count = 1.
- limit = 9, MODE_WRAP, up, step = 3, count 8, ce = 1 -> count_out = 1, tc = 1 for one cycle; next enabled cycle -> 4, tc = 0.
- limit = 15, MODE_WRAP, down, step = 3, count 1 -> 14, tc = 1; MODE_SAT, down, step = 5, count 2 -> 0, tc = 1, zero = 1; repeat -> stays 0, tc = 1.
- load = 1, ce = 1, data_load = 12, limit = 9 -> count_out = 9, max_count = 1, tc = 0; then limit = 5 with ce = 0 -> count_out = 5, tc = 1.
- limit = 9, step = 11, ce = 1, count 4 -> count holds at 4, step_err = 1 for one cycle, tc = 0; step = 0 -> hold, no pulses.
- With MOD_COUNTER_STICKY_EN: force one wrap -> sticky_tc = 1 and stays set; sticky_clr = 1 in the same cycle as a new wrap -> stays 1; sticky_clr alone -> 0.
